interval_timer_ctrl: RTL and testbench

- Controller that sequences a loadable up-counter as a programmable interval timer.
- Accepts a start command and latches the start value, terminal value, prescale ratio and mode.
- Loads the counter, advances it once every (prescale+1) clocks, and flags terminal count.
- Supports one-shot and periodic (auto-reload) modes. Sits between control logic and event consumers (sequencers, blinkers, timeouts).

---
 rtl/interval_timer_ctrl_pkg.sv | 12 +
 rtl/interval_timer_ctrl_counter_en.sv | 39 +++
 rtl/interval_timer_ctrl.sv | 136 +++++++++++++
 tb/tb_interval_timer_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller.
package interval_timer_ctrl_pkg;

  // Controller state encoding (2 bits).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/interval_timer_ctrl_counter_en.sv
// Loadable up-counter: synchronous reset, load (priority), enable-increment.
module counter_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next count: load wins over increment; increment wraps modulo 2^W.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: sequences a loadable up-counter through
// IDLE/LOAD/RUN/DONE with a prescaler and one-shot or auto-reload modes.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int BUS_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      periodic,
  input  logic [BUS_WIDTH-1:0]      load_val,
  input  logic [BUS_WIDTH-1:0]      terminal,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [BUS_WIDTH-1:0]      count,
  output logic                      busy,
  output logic                      tick,
  output logic                      done
);

  state_e                    state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] pre_q,      pre_d;
  logic [BUS_WIDTH-1:0]      sh_load_q,  sh_load_d;
  logic [BUS_WIDTH-1:0]      sh_term_q,  sh_term_d;
  logic [PRESCALE_WIDTH-1:0] sh_pre_q,   sh_pre_d;
  logic                      sh_per_q,   sh_per_d;

  logic                      ctr_ld;
  logic                      ctr_en;
  logic [BUS_WIDTH-1:0]      count_q;
  logic                      step;
  logic                      at_term;

  // Register-only decodes: prescaler rollover and terminal match.
  assign step    = (pre_q == sh_pre_q);
  assign at_term = (count_q == sh_term_q);

  // Next-state, prescaler, shadow capture and counter control.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    sh_load_d = sh_load_q;
    sh_term_d = sh_term_q;
    sh_pre_d  = sh_pre_q;
    sh_per_d  = sh_per_q;
    ctr_ld    = 1'b0;
    ctr_en    = 1'b0;
    busy      = 1'b0;
    tick      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // start wins over a coincident stop; stop alone means nothing here.
        if (start) begin
          sh_load_d = load_val;
          sh_term_d = terminal;
          sh_pre_d  = prescale;
          sh_per_d  = periodic;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          ctr_ld  = 1'b1;
          pre_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        tick = step & at_term;
        // An abort pre-empts any reload, increment or completion this cycle.
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pre_d = step ? '0 : pre_q + PRESCALE_WIDTH'(1);
          if (step) begin
            if (at_term) begin
              if (sh_per_q) begin
                ctr_ld = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              ctr_en = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, prescaler and shadow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      sh_load_q <= '0;
      sh_term_q <= '0;
      sh_pre_q  <= '0;
      sh_per_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sh_load_q <= sh_load_d;
      sh_term_q <= sh_term_d;
      sh_pre_q  <= sh_pre_d;
      sh_per_q  <= sh_per_d;
    end
  end

  counter_en #(
    .W(BUS_WIDTH)
  ) u_counter (
    .clk (clk),
    .rst (rst),
    .ld  (ctr_ld),
    .en  (ctr_en),
    .d   (sh_load_q),
    .q   (count_q)
  );

  assign count = count_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: per-cycle expected outputs
// are queued as each scenario is set up and popped one per clock.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] load_val;
  logic [7:0] terminal;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;
  } row_t;

  row_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  interval_timer_ctrl #(
    .BUS_WIDTH(8),
    .PRESCALE_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .load_val (load_val),
    .terminal (terminal),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  function automatic row_t mk(int c, logic b, logic t, logic d);
    row_t r;
    r.count = 8'(c);
    r.busy  = b;
    r.tick  = t;
    r.done  = d;
    return r;
  endfunction

  // Expected RUN-state rows from the timing rule: each count value lasts
  // P+1 cycles, N+1 values per interval, tick in the interval's last cycle.
  task automatic push_run(int ld, int tm, int p, int nrows);
    int n      = (tm - ld) & 255;
    int period = (n + 1) * (p + 1);
    for (int i = 0; i < nrows; i++) begin
      int k = i % period;
      sb.push_back(mk(ld + k / (p + 1), 1'b1, k == period - 1, 1'b0));
    end
  endtask

  // Complete one-shot run: LOAD row, RUN rows, DONE row, one IDLE row.
  task automatic push_oneshot(int prev, int ld, int tm, int p);
    int n = (tm - ld) & 255;
    sb.push_back(mk(prev, 1'b1, 1'b0, 1'b0));
    push_run(ld, tm, p, (n + 1) * (p + 1));
    sb.push_back(mk(tm, 1'b0, 1'b0, 1'b1));
    sb.push_back(mk(tm, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic set_cmd(logic st, logic sp, logic per, int ld, int tm, int p);
    start    = st;
    stop     = sp;
    periodic = per;
    load_val = 8'(ld);
    terminal = 8'(tm);
    prescale = 4'(p);
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    row_t e;
    int   n;
    rst = 1'b1;
    set_cmd(1'b1, 1'b0, 1'b1, 9, 12, 2);
    repeat (3) sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 3) begin
        rst   = 1'b0;
        start = 1'b0;
      end
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL reset row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_oneshot();
    row_t e;
    int   n;
    set_cmd(1'b1, 1'b0, 1'b0, 3, 6, 0);
    push_oneshot(0, 3, 6, 0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 1) start = 1'b0;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL oneshot row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_prescale();
    row_t e;
    int   n;
    // P=3 divide, then load==terminal at the maximum divide P=15.
    push_oneshot(6, 0, 2, 3);
    push_oneshot(2, 7, 7, 15);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 0)  set_cmd(1'b1, 1'b0, 1'b0, 0, 2, 3);
      if (i == 1)  start = 1'b0;
      if (i == 15) set_cmd(1'b1, 1'b0, 1'b0, 7, 7, 15);
      if (i == 16) start = 1'b0;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL prescale row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_periodic();
    row_t e;
    int   n;
    // Wrap through 255->0, three intervals, then abort on a terminal cycle.
    set_cmd(1'b1, 1'b0, 1'b1, 254, 1, 0);
    sb.push_back(mk(7, 1'b1, 1'b0, 1'b0));
    push_run(254, 1, 0, 12);
    sb.push_back(mk(1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1, 1'b0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 1)  start = 1'b0;
      if (i == 13) stop = 1'b1;
      if (i == 14) stop = 1'b0;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL periodic row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_stop_terminal();
    row_t e;
    int   n;
    set_cmd(1'b1, 1'b0, 1'b0, 5, 5, 0);
    sb.push_back(mk(1, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(5, 1'b1, 1'b1, 1'b0));
    repeat (3) sb.push_back(mk(5, 1'b0, 1'b0, 1'b0));
    // start+stop together in IDLE (start wins), then stop aborts LOAD.
    sb.push_back(mk(5, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(5, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(5, 1'b0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 1) start = 1'b0;
      if (i == 2) stop = 1'b1;
      if (i == 5) set_cmd(1'b1, 1'b1, 1'b0, 9, 20, 0);
      if (i == 6) start = 1'b0;
      if (i == 7) stop = 1'b0;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL stop_terminal row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  task automatic test_start_ignored();
    row_t e;
    int   n;
    // Periodic so the reload after terminal exposes the shadow load value.
    set_cmd(1'b1, 1'b0, 1'b1, 0, 9, 0);
    sb.push_back(mk(5, 1'b1, 1'b0, 1'b0));
    push_run(0, 9, 0, 13);
    sb.push_back(mk(2, 1'b0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 1) start = 1'b0;
      if (i == 5) begin
        start    = 1'b1;
        load_val = 8'd7;
      end
      if (i == 6)  start = 1'b0;
      if (i == 14) stop = 1'b1;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL start_ignored row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    row_t e;
    int   n;
    set_cmd(1'b1, 1'b0, 1'b0, 0, 9, 2);
    sb.push_back(mk(2, 1'b1, 1'b0, 1'b0));
    push_run(0, 9, 2, 13);
    sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(0, 1'b0, 1'b0, 1'b0));
    push_oneshot(0, 1, 2, 1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      if (i == 1)  start = 1'b0;
      if (i == 14) rst = 1'b1;
      if (i == 15) rst = 1'b0;
      if (i == 16) set_cmd(1'b1, 1'b0, 1'b0, 1, 2, 1);
      if (i == 17) start = 1'b0;
      clk_cycle();
      e = sb.pop_front();
      checks++;
      if ({count, busy, tick, done} !== e) begin
        failures++;
        $display("FAIL reset_mid_run row=%0d got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                 i, count, busy, tick, done, e.count, e.busy, e.tick, e.done);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_prescale();
    test_periodic();
    test_stop_terminal();
    test_start_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
